// File: rtl/uidma_axi_wr.sv
// rtl/uidma_axi_wr.sv - frame-buffer write-DMA to AXI4 INCR burst write master
module uidma_axi_wr #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 64
) (
  input  logic                        ui_clk,
  input  logic                        ui_rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   dma_waddr,
  input  logic                        dma_wareq,
  input  logic [15:0]                 dma_wsize,
  output logic                        dma_wbusy,
  input  logic [AXI_DATA_WIDTH-1:0]   dma_wdata,
  input  logic                        dma_wready,
  output logic                        dma_wvalid,
  output logic                        dma_werr,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);

  localparam int BPB    = AXI_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BPB);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [15:0]               rem;
  logic [8:0]                len;
  logic [8:0]                beat_cnt;
  logic [8:0]                len_c;
  logic [12:0]               b4k;
  logic [16:0]               min_a;
  logic                      w_hs;

  // Burst length limited by remaining beats, max burst and distance to the next 4 KB page
  always_comb begin
    b4k   = (13'd4096 - {1'b0, addr[11:0]}) >> BSHIFT;
    min_a = ({1'b0, rem} < 17'(MAX_BURST_LEN)) ? {1'b0, rem} : 17'(MAX_BURST_LEN);
    len_c = (min_a < {4'b0, b4k}) ? min_a[8:0] : b4k[8:0];
  end

  assign m_axi_awsize  = 3'(BSHIFT);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = dma_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == S_W) & dma_wready;
  assign m_axi_wlast   = (state == S_W) & (beat_cnt == len - 9'd1);
  assign w_hs          = m_axi_wvalid & m_axi_wready;
  assign dma_wvalid    = w_hs;

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      rem           <= '0;
      len           <= '0;
      beat_cnt      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      dma_wbusy     <= 1'b0;
      dma_werr      <= 1'b0;
    end else begin
      dma_werr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dma_wareq) begin
            addr      <= dma_waddr & ~AXI_ADDR_WIDTH'(BPB - 1);
            rem       <= dma_wsize;
            dma_wbusy <= 1'b1;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          if (rem == 16'd0) begin
            dma_wbusy <= 1'b0;
            state     <= S_IDLE;
          end else begin
            len           <= len_c;
            m_axi_awaddr  <= addr;
            m_axi_awlen   <= 8'(len_c - 9'd1);
            beat_cnt      <= '0;
            m_axi_awvalid <= 1'b1;
            state         <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi_wlast) begin
              m_axi_bready <= 1'b1;
              state        <= S_B;
            end
          end
        end
        S_B: begin
          // Error responses are reported but the transfer carries on
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            dma_werr     <= (m_axi_bresp != 2'b00);
            rem          <= rem - 16'(len);
            addr         <= addr + (AXI_ADDR_WIDTH'(len) << BSHIFT);
            if (rem == 16'(len)) begin
              dma_wbusy <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uidma_axi_wr.sv
// tb/tb_uidma_axi_wr.sv - self-checking bench for uidma_axi_wr against a burst-split reference model
module tb_uidma_axi_wr;
  localparam int DW = 128;
  localparam int AW = 32;

  logic          ui_clk = 1'b0;
  logic          ui_rst;
  logic [AW-1:0] dma_waddr;
  logic          dma_wareq;
  logic [15:0]   dma_wsize;
  logic          dma_wbusy;
  logic [DW-1:0] dma_wdata;
  logic          dma_wready;
  logic          dma_wvalid;
  logic          dma_werr;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;

  uidma_axi_wr dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .dma_waddr(dma_waddr), .dma_wareq(dma_wareq), .dma_wsize(dma_wsize),
    .dma_wbusy(dma_wbusy), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_wvalid(dma_wvalid), .dma_werr(dma_werr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 ui_clk = ~ui_clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] got_q[$];
  logic [AW-1:0] aw_addr_q[$];
  logic [7:0]    aw_len_q[$];
  int            wlast_pos[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];

  int cycle, beats, busy_cycles, werr_cnt, pop_err, order_err;
  int fall_cycle, last_b_cycle, b_idx, err_burst, gap;
  bit w_open, b_pend, busy_prev, seen_busy, timeout;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    fifo_q.delete(); exp_data.delete(); got_q.delete();
    aw_addr_q.delete(); aw_len_q.delete(); wlast_pos.delete();
    beats = 0; busy_cycles = 0; werr_cnt = 0; pop_err = 0; order_err = 0;
    fall_cycle = -1; last_b_cycle = -100; b_idx = 0;
    w_open = 0; b_pend = 0; busy_prev = 0; seen_busy = 0;
  endtask

  // One clock: drive inputs after the falling edge, then observe what the next rising edge will commit
  task automatic cyc();
    bit hs;
    @(negedge ui_clk);
    cycle++;
    m_axi_awready = ($urandom_range(99) >= gap);
    m_axi_wready  = ($urandom_range(99) >= gap);
    dma_wready    = (fifo_q.size() > 0) && ($urandom_range(99) >= gap);
    dma_wdata     = (fifo_q.size() > 0) ? fifo_q[0] : {$urandom, $urandom, $urandom, $urandom};
    m_axi_bvalid  = b_pend && ($urandom_range(99) >= gap);
    m_axi_bresp   = (b_pend && b_idx == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (dma_wbusy) begin busy_cycles++; seen_busy = 1; end
    if (busy_prev && !dma_wbusy) fall_cycle = cycle;
    busy_prev = dma_wbusy;
    if (dma_werr) werr_cnt++;
    if (m_axi_awvalid && m_axi_awready) begin
      if (w_open || b_pend) order_err++;
      aw_addr_q.push_back(m_axi_awaddr);
      aw_len_q.push_back(m_axi_awlen);
      w_open = 1;
    end
    if (m_axi_wvalid && !w_open) order_err++;
    hs = m_axi_wvalid && m_axi_wready;
    if (dma_wvalid !== hs) pop_err++;
    if (hs) begin
      got_q.push_back(m_axi_wdata);
      beats++;
      void'(fifo_q.pop_front());
      if (m_axi_wlast) begin
        wlast_pos.push_back(beats);
        w_open = 0;
        b_pend = 1;
      end
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_pend = 0;
      b_idx++;
      last_b_cycle = cycle;
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input int sz);
    logic [DW-1:0] d;
    clear_rec();
    for (int i = 0; i < sz; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(d);
      exp_data.push_back(d);
    end
    dma_waddr = a;
    dma_wsize = 16'(sz);
    dma_wareq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (dma_wbusy) break;
    end
    dma_wareq = 1'b0;
    check("req_ack", dma_wbusy, 1);
  endtask

  task automatic run_idle();
    timeout = 1;
    for (int i = 0; i < 6000; i++) begin
      if (seen_busy && !dma_wbusy) begin timeout = 0; break; end
      cyc();
    end
    check("done_timeout", timeout, 0);
  endtask

  // Reference: walk the transfer in page-bounded, size-bounded chunks
  task automatic check_xfer(input logic [AW-1:0] a0, input int sz, input int eb);
    logic [AW-1:0] a;
    int r, l, room, cum, n;
    exp_addr.delete(); exp_len.delete();
    a = a0 & ~32'hF;
    r = sz;
    while (r > 0) begin
      room = (4096 - int'(a % 4096)) / 16;
      l = r;
      if (l > 64) l = 64;
      if (l > room) l = room;
      exp_addr.push_back(a);
      exp_len.push_back(l);
      a = a + 32'(l * 16);
      r = r - l;
    end
    check("aw_count", aw_addr_q.size(), exp_addr.size());
    n = (aw_addr_q.size() < exp_addr.size()) ? aw_addr_q.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check("awaddr", aw_addr_q[i], exp_addr[i]);
      check("awlen", aw_len_q[i], exp_len[i] - 1);
      check("aw_4k", (int'(aw_addr_q[i] % 4096) + (int'(aw_len_q[i]) + 1) * 16) <= 4096, 1);
    end
    check("beats", got_q.size(), sz);
    n = (got_q.size() < sz) ? got_q.size() : sz;
    for (int i = 0; i < n; i++) check("wdata", got_q[i], exp_data[i]);
    check("wlast_count", wlast_pos.size(), exp_len.size());
    cum = 0;
    n = (wlast_pos.size() < exp_len.size()) ? wlast_pos.size() : exp_len.size();
    for (int i = 0; i < n; i++) begin
      cum += exp_len[i];
      check("wlast_pos", wlast_pos[i], cum);
    end
    check("werr_pulses", werr_cnt, (eb < exp_addr.size()) ? 1 : 0);
    check("pop_align", pop_err, 0);
    check("order", order_err, 0);
    if (sz > 0) check("busy_fall", fall_cycle, last_b_cycle + 1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rs, aw_before, busy_before;
    cycle = 0; gap = 0; err_burst = 99;
    clear_rec();
    ui_rst = 1'b1; dma_wareq = 1'b0; dma_waddr = '0; dma_wsize = '0;
    dma_wdata = '0; dma_wready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    cyc(); cyc();
    check("rst_wbusy", dma_wbusy, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_awlen", m_axi_awlen, 0);
    check("awsize", m_axi_awsize, 3'd4);
    check("awburst", m_axi_awburst, 2'b01);
    check("wstrb", m_axi_wstrb, 16'hFFFF);
    ui_rst = 1'b0;
    cyc();

    // Plan 1: multi-burst, everything ready
    start_xfer(32'h0100_0000, 240); run_idle(); check_xfer(32'h0100_0000, 240, 99);

    // Plan 2: 4 KB page split
    start_xfer(32'h0000_0F80, 16); run_idle(); check_xfer(32'h0000_0F80, 16, 99);

    // Plan 3: back-pressure on both sides, then random transfers
    gap = 30;
    start_xfer($urandom & 32'hFFFF_FFF0, 64); run_idle(); check_xfer(dma_waddr, 64, 99);
    gap = 20;
    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rs = $urandom_range(300, 1);
      start_xfer(ra, rs); run_idle(); check_xfer(ra, rs, 99);
    end

    // Plan 4: error response on the second burst
    gap = 10; err_burst = 1;
    start_xfer(32'h0200_0000, 200); run_idle(); check_xfer(32'h0200_0000, 200, 1);
    err_burst = 99; gap = 0;

    // Plan 5: zero-length request and a request pulse while busy
    start_xfer(32'h0300_0000, 0); run_idle(); check_xfer(32'h0300_0000, 0, 99);
    check("zero_busy_cycles", busy_cycles, 1);
    start_xfer(32'h0400_0000, 16);
    cyc(); cyc();
    dma_wsize = 16'd5; dma_wareq = 1'b1;
    cyc();
    dma_wareq = 1'b0;
    run_idle(); check_xfer(32'h0400_0000, 16, 99);
    aw_before = aw_addr_q.size(); busy_before = busy_cycles;
    for (int i = 0; i < 10; i++) cyc();
    check("no_extra_aw", aw_addr_q.size(), aw_before);
    check("no_extra_busy", busy_cycles, busy_before);

    // Plan 6: reset in the middle of burst 2
    start_xfer(32'h0100_0000, 240);
    timeout = 1;
    for (int i = 0; i < 2000; i++) begin
      if (aw_addr_q.size() >= 2 && beats >= 70) begin timeout = 0; break; end
      cyc();
    end
    check("mid_w_reached", timeout, 0);
    ui_rst = 1'b1;
    cyc();
    check("mrst_wbusy", dma_wbusy, 0);
    check("mrst_dma_wvalid", dma_wvalid, 0);
    check("mrst_werr", dma_werr, 0);
    check("mrst_awvalid", m_axi_awvalid, 0);
    check("mrst_wvalid", m_axi_wvalid, 0);
    check("mrst_wlast", m_axi_wlast, 0);
    check("mrst_bready", m_axi_bready, 0);
    check("mrst_awaddr", m_axi_awaddr, 0);
    check("mrst_awlen", m_axi_awlen, 0);
    ui_rst = 1'b0;
    start_xfer(32'h0300_0040, 8); run_idle(); check_xfer(32'h0300_0040, 8, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
